// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers, one step per cycle.
// Define MULT_DIV_UNIT_DIV_EN to build the divider datapath; without it divide ops report err.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_mstep;
  logic [2*WIDTH-1:0] w_prod_fin;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH-1:0]   w_a_lat;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               w_finish;
  logic               w_res_err;
  logic               w_sgn;

  assign w_sgn   = ~op[0];
  assign w_a_abs = (w_sgn && a[WIDTH-1]) ? -a : a;
  assign w_b_abs = (w_sgn && b[WIDTH-1]) ? -b : b;

  // Shift-add step: low half of r_acc holds the remaining multiplier bits.
  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : {WIDTH{1'b0}})};
  assign w_mstep    = {w_msum, r_acc[WIDTH-1:1]};
  assign w_prod_fin = r_neg_q ? -w_mstep : w_mstep;

`ifdef MULT_DIV_UNIT_DIV_EN
  logic               r_neg_r;
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH-1:0]   w_dsub;
  logic [WIDTH-1:0]   w_drem;
  logic [WIDTH-1:0]   w_dq_fin;
  logic [WIDTH-1:0]   w_dr_fin;
  logic [2*WIDTH-1:0] w_dstep;
  logic               w_dge;

  // Restoring step: r_acc is {remainder, dividend/quotient}; a zero divisor keeps the raw dividend.
  assign w_a_lat  = (op[1] && (b == {WIDTH{1'b0}})) ? a : w_a_abs;
  assign w_dshift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_dge    = (w_dshift >= {1'b0, r_opb});
  assign w_dsub   = w_dshift[WIDTH-1:0] - r_opb;
  assign w_drem   = w_dge ? w_dsub : w_dshift[WIDTH-1:0];
  assign w_dstep  = {w_drem, r_acc[WIDTH-2:0], w_dge};
  assign w_dq_fin = r_neg_q ? -w_dstep[WIDTH-1:0] : w_dstep[WIDTH-1:0];
  assign w_dr_fin = r_neg_r ? -w_drem : w_drem;
`else
  assign w_a_lat  = w_a_abs;
`endif

  // Step selection and final result formatting for the cycle that enters DONE.
  always_comb begin
    w_step    = w_mstep;
    w_finish  = (r_cnt == CW'(1));
    w_res_hi  = w_prod_fin[2*WIDTH-1:WIDTH];
    w_res_lo  = w_prod_fin[WIDTH-1:0];
    w_res_err = 1'b0;
    if (r_is_div) begin
`ifdef MULT_DIV_UNIT_DIV_EN
      if (r_opb == {WIDTH{1'b0}}) begin
        w_finish  = 1'b1;
        w_res_hi  = r_acc[WIDTH-1:0];
        w_res_lo  = {WIDTH{1'b1}};
        w_res_err = 1'b1;
      end else begin
        w_step    = w_dstep;
        w_res_hi  = w_dr_fin;
        w_res_lo  = w_dq_fin;
      end
`else
      w_finish  = 1'b1;
      w_res_hi  = {WIDTH{1'b0}};
      w_res_lo  = {WIDTH{1'b0}};
      w_res_err = 1'b1;
`endif
    end else begin
      w_step = w_mstep;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (w_finish) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, HI/LO and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_opb    <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_opb    <= op[1] ? w_b_abs : w_a_abs;
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_lat : w_b_abs)};
            r_neg_q  <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_cnt    <= CW'(WIDTH);
`ifdef MULT_DIV_UNIT_DIV_EN
            r_neg_r  <= w_sgn & a[WIDTH-1];
`endif
          end else begin
            if (hi_wr) r_hi <= a;
            if (lo_wr) r_lo <= a;
          end
        end
        ST_CALC: begin
          r_acc <= w_step;
          if (w_finish) begin
            r_cnt <= {CW{1'b0}};
            r_hi  <= w_res_hi;
            r_lo  <= w_res_lo;
            r_err <= w_res_err;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          r_cnt <= {CW{1'b0}};
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
